// File: rtl/aurora_pkg.sv
// Shared types and default sizing for the Aurora TX arbiter slice.
package aurora_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_NUM_REQ = 4;
    localparam int unsigned DEFAULT_DATA_W  = 64;
    localparam int unsigned DEFAULT_CNT_W   = 16;

endpackage

// File: rtl/aurora_tx_arbiter_rr_arbiter.sv
// Round-robin next-grant picker: first requester above last_grant, else lowest.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] onehot;

    // Mask of requesters that come after last_grant in the rotation.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            upper_mask[i] = (IDX_W'(i) > last_grant);
        end
    end

    // Lowest set bit of the wrapped request vector, then encode to an index.
    always_comb begin
        upper_req   = req & upper_mask;
        pick        = (|upper_req) ? upper_req : req;
        onehot      = pick & (~pick + NUM_REQ'(1));
        grant_valid = |req;
        grant_idx   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (onehot[i]) begin
                grant_idx = grant_idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/aurora_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one Aurora TX lane among NUM_REQ streams.
module aurora_tx_arbiter
    import aurora_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic                           user_clk,
    input  logic                           user_reset,
    input  logic                           channel_up,
    input  logic [NUM_REQ*DATA_W-1:0]      s_req_tdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0]  s_req_tkeep,
    input  logic [NUM_REQ-1:0]             s_req_tlast,
    input  logic [NUM_REQ-1:0]             s_req_tvalid,
    output logic [NUM_REQ-1:0]             s_req_tready,
    output logic [DATA_W-1:0]              m_axi_tx_tdata,
    output logic [DATA_W/8-1:0]            m_axi_tx_tkeep,
    output logic                           m_axi_tx_tlast,
    output logic                           m_axi_tx_tvalid,
    input  logic                           m_axi_tx_tready,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic [CNT_W-1:0]               frame_cnt,
    output logic [CNT_W-1:0]               abort_cnt
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;
    logic               grant_load_c;
    logic               frame_inc_c;
    logic               abort_inc_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req         (s_req_tvalid),
        .last_grant  (last_grant),
        .grant_idx   (rr_idx),
        .grant_valid (rr_any)
    );

    // Next-state logic and the combinational requester-to-lane connection.
    always_comb begin
        state_nxt       = state;
        grant_load_c    = 1'b0;
        frame_inc_c     = 1'b0;
        abort_inc_c     = 1'b0;
        s_req_tready    = '0;
        m_axi_tx_tvalid = 1'b0;
        m_axi_tx_tdata  = '0;
        m_axi_tx_tkeep  = '0;
        m_axi_tx_tlast  = 1'b0;
        case (state)
            IDLE: begin
                if (channel_up && rr_any) begin
                    grant_load_c = 1'b1;
                    state_nxt    = PASS;
                end
            end
            PASS: begin
                if (!channel_up) begin
                    state_nxt = FLUSH;
                end else begin
                    m_axi_tx_tvalid        = s_req_tvalid[grant_id];
                    s_req_tready[grant_id] = m_axi_tx_tready;
                    if (s_req_tvalid[grant_id]) begin
                        m_axi_tx_tdata = s_req_tdata[32'(grant_id)*DATA_W +: DATA_W];
                        m_axi_tx_tkeep = s_req_tkeep[32'(grant_id)*KEEP_W +: KEEP_W];
                        m_axi_tx_tlast = s_req_tlast[grant_id];
                    end
                    if (s_req_tvalid[grant_id] && m_axi_tx_tready && s_req_tlast[grant_id]) begin
                        frame_inc_c = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            FLUSH: begin
                // Drain the interrupted frame regardless of link state.
                s_req_tready[grant_id] = 1'b1;
                if (s_req_tvalid[grant_id] && s_req_tlast[grant_id]) begin
                    abort_inc_c = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and saturating status counters.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant_id   <= '0;
            frame_cnt  <= '0;
            abort_cnt  <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (grant_load_c) begin
                grant_id <= rr_idx;
            end
            if (frame_inc_c) begin
                last_grant <= grant_id;
                if (frame_cnt != '1) begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
            if (abort_inc_c && (abort_cnt != '1)) begin
                abort_cnt <= abort_cnt + CNT_W'(1);
            end
        end
    end

endmodule
